accum_datapath_param: RTL and testbench
=======================================

Name: accum_datapath_param

Overview:
- Parametrised successor of the 8-bit accumulator datapath, with configurable data width, address width and register-file depth.
- Replaces the single R register with NUM_R general registers. Adds carry and negative flags.
- Internal memory is replaced by an external req/ack memory port with variable latency. A command sequencer executes one micro-command per cmd handshake, including multi-byte address fetch.
- Sits between the control unit (issues commands, reads opcode/flags) and the system memory.

Parameters:
- DATA_W, 8, accumulator/register/memory word width (>=4).
- ADDR_W, 16, memory address width; must be an integer multiple of DATA_W.
- NUM_R, 4, general registers (power of 2, >=2); RSEL_W = log2(NUM_R).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  datapath idle, accepts command
- cmd_op  in  4  command code (see Behaviour)
- cmd_rsel  in  RSEL_W  register index for register/ALU commands
- done  out  1  one-cycle pulse when a command completes
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  request is a write
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data (=AC)
- mem_ack  in  1  request completes; read data valid this cycle
- mem_rdata  in  DATA_W  read data
- opcode  out  DATA_W  instruction register
- flag_z, flag_c, flag_n  out  1  zero, carry, negative flags
- pc_out  out  ADDR_W  current PC
- ac_out  out  DATA_W  accumulator (debug)

Behaviour:
Reset (reset==0 at posedge):
- PC=RESET_PC; AC, all R, IR and ADDR register = 0.
- flag_z=1, flag_c=0, flag_n=0.
- FSM returns to IDLE; mem_req=0, done=0.
- Reset mid-transaction abandons the transaction. No write completes after reset is sampled.

FSM states IDLE, MEM, EXEC, DONE:
- cmd_ready=1 only in IDLE. A command is accepted when cmd_valid && cmd_ready.
- Register-only commands: IDLE->EXEC->DONE. Result is written at the end of the EXEC cycle; done is asserted in DONE, which is 2 cycles after acceptance.
- Memory commands: IDLE->MEM. In MEM, mem_req=1 and addr/we/wdata are stable until the cycle mem_ack=1.
  - FETCH_ADDR stays in MEM for ADDR_BYTES=ADDR_W/DATA_W acks, with an internal byte counter.
  - After the final ack: ->DONE.
- DONE->IDLE unconditionally. A mem_ack arriving in the same cycle as mem_req rising is legal (zero-wait memory).

Commands (cmd_op):
- 0 NOP.
- 1 FETCH_OP: read mem[PC] -> IR; PC+=1.
- 2 FETCH_ADDR: read ADDR_BYTES words from mem[PC], MSB first, shifting into the ADDR register; PC+=1 per ack. ADDR updates only on the final ack (stage bytes internally).
- 3 LOAD: AC <= mem[ADDR].
- 4 STORE: mem[ADDR] <= AC (mem_we=1).
- 5 MOV_RA: R[rsel] <= AC.
- 6 MOV_AR: AC <= R[rsel].
- 7 ALU: AC <= AC op R[rsel], with op = IR[2:0]:
  - 0 ADD, 1 SUB (AC-R), 2 AND, 3 OR, 4 XOR, 5 NOT AC, 6 INC AC, 7 CLR.
- 8 JMP: PC <= ADDR.
- 9 JMPZ: PC <= ADDR if flag_z, else no change.
- 10..15: treated as NOP, still handshake and pulse done.

Arithmetic and flags:
- Arithmetic is DATA_W-bit wrap-around.
- C = carry out for ADD/INC; C = borrow for SUB (1 when AC<R unsigned); unchanged for logic ops, CLR, LOAD and MOV_AR.
- Z = (new AC==0) and N = new AC[DATA_W-1], updated on every AC write (LOAD, MOV_AR, ALU).
- PC increment wraps from all-ones to 0.
- Commands presented while cmd_ready=0 are ignored; the control unit must hold cmd_valid until accepted.

Test Plan:
- Reset, then FETCH_OP with mem[0]=0x07 and ack latency 3 -> opcode=0x07, pc_out=1; done high 1 cycle after the ack cycle; mem_req high exactly 4 cycles.
- DATA_W=8/ADDR_W=16: FETCH_ADDR with mem[1]=0x12, mem[2]=0x34 (zero-wait ack), then JMP -> pc_out=0x1234; ADDR unchanged until 2nd ack.
- LOAD 0xFF, MOV_RA rsel=2, LOAD 0x01, IR op ADD (IR=0x00) ALU rsel=2 -> ac_out=0x00, flag_z=1, flag_c=1, flag_n=0; then IR=0x01 SUB with R2=0xFF -> ac_out=0x01, flag_c=1.
- STORE with AC=0x5A, ADDR=0x00F0 -> mem_we=1, mem_addr=0x00F0, mem_wdata=0x5A held stable for the 2-cycle stall until ack; JMPZ with flag_z=0 -> PC unchanged.
- Assert reset during the MEM state of a STORE before ack -> next cycle mem_req=0, pc_out=RESET_PC, flag_z=1, cmd_ready=1; later ack ignored.
- Re-run ALU ADD/INC wrap with DATA_W=16, ADDR_W=32, NUM_R=8: 0xFFFF INC -> 0x0000, flag_c=1, flag_z=1; FETCH_ADDR takes exactly 2 acks.

Source files
------------

// File: rtl/accum_datapath_param.sv
// Parametrised accumulator datapath: AC, NUM_R registers, Z/C/N flags,
// command sequencer and a req/ack memory port with variable latency.
module accum_datapath_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int NUM_R = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_op,
    input  logic [$clog2(NUM_R)-1:0] cmd_rsel,
    output logic                     done,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [DATA_W-1:0]        opcode,
    output logic                     flag_z,
    output logic                     flag_c,
    output logic                     flag_n,
    output logic [ADDR_W-1:0]        pc_out,
    output logic [DATA_W-1:0]        ac_out
);

    localparam int RSEL_W = $clog2(NUM_R);
    localparam int ABYTES = ADDR_W / DATA_W;
    localparam int CNT_W = $clog2(ABYTES) + 1;

    localparam logic [3:0] OP_FETCH_OP   = 4'd1;
    localparam logic [3:0] OP_FETCH_ADDR = 4'd2;
    localparam logic [3:0] OP_LOAD       = 4'd3;
    localparam logic [3:0] OP_STORE      = 4'd4;
    localparam logic [3:0] OP_MOV_RA     = 4'd5;
    localparam logic [3:0] OP_MOV_AR     = 4'd6;
    localparam logic [3:0] OP_ALU        = 4'd7;
    localparam logic [3:0] OP_JMP        = 4'd8;
    localparam logic [3:0] OP_JMPZ       = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        EXEC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [3:0]        op_q;
    logic [RSEL_W-1:0] rsel_q;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] stage;
    logic [ADDR_W-1:0] addr_shift;
    logic [DATA_W-1:0] ac;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] regs [NUM_R];
    logic [DATA_W-1:0] r_sel;
    logic [CNT_W-1:0]  cnt;
    logic              fz, fc, fn;
    logic              accept;
    logic              is_mem_cmd;
    logic              fetch_last;
    logic              last_ack;

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;

    assign accept     = cmd_valid && cmd_ready;
    assign is_mem_cmd = (cmd_op >= OP_FETCH_OP) && (cmd_op <= OP_STORE);
    assign fetch_last = (cnt == CNT_W'(ABYTES - 1));
    assign last_ack   = mem_ack && ((op_q != OP_FETCH_ADDR) || fetch_last);
    assign r_sel      = regs[rsel_q];

    // Address bytes arrive MSB first and are shifted in from the bottom.
    assign addr_shift = (stage << DATA_W) | ADDR_W'(mem_rdata);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = is_mem_cmd ? MEM : EXEC;
                end
            end
            MEM: begin
                if (last_ack) begin
                    state_nxt = DONE;
                end
            end
            EXEC:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        done      = (state == DONE);
        mem_req   = (state == MEM);
        mem_we    = (state == MEM) && (op_q == OP_STORE);
    end

    assign mem_addr  = ((op_q == OP_FETCH_OP) || (op_q == OP_FETCH_ADDR))
                       ? pc : addr_q;
    assign mem_wdata = ac;
    assign opcode    = ir;
    assign flag_z    = fz;
    assign flag_c    = fc;
    assign flag_n    = fn;
    assign pc_out    = pc;
    assign ac_out    = ac;

    always_comb begin
        sum     = '0;
        alu_res = ac;
        alu_c   = fc;
        case (ir[2:0])
            3'd0: begin
                sum     = {1'b0, ac} + {1'b0, r_sel};
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
            end
            3'd1: begin
                alu_res = ac - r_sel;
                alu_c   = (ac < r_sel);
            end
            3'd2: alu_res = ac & r_sel;
            3'd3: alu_res = ac | r_sel;
            3'd4: alu_res = ac ^ r_sel;
            3'd5: alu_res = ~ac;
            3'd6: begin
                sum     = {1'b0, ac} + (DATA_W + 1)'(1);
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
            end
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q   <= '0;
            rsel_q <= '0;
            pc     <= RESET_PC;
            addr_q <= '0;
            stage  <= '0;
            ac     <= '0;
            ir     <= '0;
            cnt    <= '0;
            fz     <= 1'b1;
            fc     <= 1'b0;
            fn     <= 1'b0;
            for (int i = 0; i < NUM_R; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (accept) begin
                op_q   <= cmd_op;
                rsel_q <= cmd_rsel;
                cnt    <= '0;
            end
            if ((state == MEM) && mem_ack) begin
                case (op_q)
                    OP_FETCH_OP: begin
                        ir <= mem_rdata;
                        pc <= pc + ADDR_W'(1);
                    end
                    OP_FETCH_ADDR: begin
                        pc    <= pc + ADDR_W'(1);
                        cnt   <= cnt + CNT_W'(1);
                        stage <= addr_shift;
                        if (fetch_last) begin
                            addr_q <= addr_shift;
                        end
                    end
                    OP_LOAD: begin
                        ac <= mem_rdata;
                        fz <= (mem_rdata == '0);
                        fn <= mem_rdata[DATA_W-1];
                    end
                    default: ;
                endcase
            end
            if (state == EXEC) begin
                case (op_q)
                    OP_MOV_RA: regs[rsel_q] <= ac;
                    OP_MOV_AR: begin
                        ac <= r_sel;
                        fz <= (r_sel == '0);
                        fn <= r_sel[DATA_W-1];
                    end
                    OP_ALU: begin
                        ac <= alu_res;
                        fc <= alu_c;
                        fz <= (alu_res == '0);
                        fn <= alu_res[DATA_W-1];
                    end
                    OP_JMP: pc <= addr_q;
                    OP_JMPZ: begin
                        if (fz) begin
                            pc <= addr_q;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_accum_datapath_param.sv
// Bench for accum_datapath_param: directed scenarios plus random commands
// against a behavioural model; a second wide instance covers 16/32-bit.
module tb_accum_datapath_param;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [1:0]  cmd_rsel = '0;
    logic        done;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [7:0]  opcode;
    logic        flag_z, flag_c, flag_n;
    logic [15:0] pc_out;
    logic [7:0]  ac_out;

    accum_datapath_param #(
        .DATA_W(8), .ADDR_W(16), .NUM_R(4), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rsel(cmd_rsel), .done(done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .opcode(opcode), .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
        .pc_out(pc_out), .ac_out(ac_out)
    );

    logic        cmd_valid2 = 1'b0;
    logic        cmd_ready2;
    logic [3:0]  cmd_op2 = '0;
    logic [2:0]  cmd_rsel2 = '0;
    logic        done2;
    logic        mem_req2, mem_we2, mem_ack2;
    logic [31:0] mem_addr2;
    logic [15:0] mem_wdata2, mem_rdata2;
    logic [15:0] opcode2;
    logic        flag_z2, flag_c2, flag_n2;
    logic [31:0] pc_out2;
    logic [15:0] ac_out2;

    accum_datapath_param #(
        .DATA_W(16), .ADDR_W(32), .NUM_R(8), .RESET_PC(32'h0)
    ) dut2 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_op(cmd_op2), .cmd_rsel(cmd_rsel2), .done(done2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_ack(mem_ack2), .mem_rdata(mem_rdata2),
        .opcode(opcode2), .flag_z(flag_z2), .flag_c(flag_c2), .flag_n(flag_n2),
        .pc_out(pc_out2), .ac_out(ac_out2)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Memory responder: ack after lat wait cycles, or a forced stray ack.
    logic [7:0] mem [65536];
    int   lat = 0;
    int   wcnt = 0;
    logic stray = 1'b0;

    assign mem_ack   = (mem_req && (wcnt == lat)) || stray;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!reset || !mem_req || mem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (reset && mem_req && mem_we && mem_ack) mem[mem_addr] <= mem_wdata;
    end

    logic [15:0] mem2 [32];
    assign mem_ack2   = mem_req2;
    assign mem_rdata2 = mem2[mem_addr2[4:0]];

    // Behavioural model of the architectural state.
    int m_pc, m_ac, m_ir, m_addr, m_z, m_c, m_n;
    int m_r [4];
    logic chk_en = 1'b0;

    task automatic m_reset();
        m_pc = 0; m_ac = 0; m_ir = 0; m_addr = 0;
        m_z = 1; m_c = 0; m_n = 0;
        for (int i = 0; i < 4; i++) m_r[i] = 0;
    endtask

    task automatic m_zn();
        m_z = (m_ac == 0) ? 1 : 0;
        m_n = (m_ac >= 128) ? 1 : 0;
    endtask

    task automatic m_alu(int rs);
        int a, b, s;
        a = m_ac;
        b = m_r[rs];
        case (m_ir % 8)
            0: begin s = a + b; m_c = (s > 255) ? 1 : 0; m_ac = s % 256; end
            1: begin m_c = (a < b) ? 1 : 0; m_ac = (a - b + 256) % 256; end
            2: m_ac = a & b;
            3: m_ac = a | b;
            4: m_ac = a ^ b;
            5: m_ac = 255 - a;
            6: begin s = a + 1; m_c = (s > 255) ? 1 : 0; m_ac = s % 256; end
            default: m_ac = 0;
        endcase
        m_zn();
    endtask

    always @(negedge clk) begin
        if (chk_en && reset && cmd_ready) begin
            chk("pc", pc_out, m_pc);
            chk("ac", ac_out, m_ac);
            chk("ir", opcode, m_ir);
            chk("z", flag_z, m_z);
            chk("c", flag_c, m_c);
            chk("n", flag_n, m_n);
            chk("idle_req", mem_req, 0);
            chk("idle_done", done, 0);
        end
    end

    int          last_reqc;
    logic [15:0] last_addr;
    logic [7:0]  last_wdata;
    logic        last_we;

    task automatic run_cmd(int op, int rs, int l);
        int acks, reqc, ack_k, done_k, exp_acks;
        logic fresh;
        logic [15:0] a0;
        logic [7:0] w0;
        logic we0;
        int ea;
        acks = 0; reqc = 0; ack_k = 0; done_k = 0; fresh = 1'b1;
        a0 = '0; w0 = '0; we0 = 1'b0;
        @(negedge clk);
        lat = l;
        cmd_valid = 1'b1;
        cmd_op = 4'(op);
        cmd_rsel = 2'(rs);
        chk("ready", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (mem_req) begin
                reqc++;
                if (fresh) begin
                    a0 = mem_addr; w0 = mem_wdata; we0 = mem_we;
                    ea = (op == 1 || op == 2) ? (m_pc + acks) % 65536 : m_addr;
                    chk("req_addr", mem_addr, ea);
                    chk("req_we", mem_we, (op == 4) ? 1 : 0);
                    if (op == 4) chk("req_wdata", mem_wdata, m_ac);
                end else begin
                    chk("hold_addr", mem_addr, a0);
                    chk("hold_wdata", mem_wdata, w0);
                    chk("hold_we", mem_we, we0);
                end
                if (mem_ack) begin
                    acks++;
                    ack_k = k;
                    fresh = 1'b1;
                end else begin
                    fresh = 1'b0;
                end
            end
            if (done) begin
                done_k = k;
                break;
            end
        end
        last_reqc = reqc; last_addr = a0; last_wdata = w0; last_we = we0;
        if (done_k == 0) begin
            chk("done_timeout", 0, 1);
        end else if (op >= 1 && op <= 4) begin
            exp_acks = (op == 2) ? 2 : 1;
            chk("acks", acks, exp_acks);
            chk("done_after_ack", done_k, ack_k + 1);
            chk("req_cycles", reqc, exp_acks * (l + 1));
        end else begin
            chk("reg_acks", acks, 0);
            chk("reg_done_lat", done_k, 2);
        end
        case (op)
            1: begin m_ir = mem[m_pc]; m_pc = (m_pc + 1) % 65536; end
            2: begin
                m_addr = mem[m_pc] * 256 + mem[(m_pc + 1) % 65536];
                m_pc = (m_pc + 2) % 65536;
            end
            3: begin m_ac = mem[m_addr]; m_zn(); end
            5: m_r[rs] = m_ac;
            6: begin m_ac = m_r[rs]; m_zn(); end
            7: m_alu(rs);
            8: m_pc = m_addr;
            9: if (m_z == 1) m_pc = m_addr;
            default: ;
        endcase
    endtask

    task automatic run2(int op, int rs, output int acks);
        int done_k;
        acks = 0; done_k = 0;
        @(negedge clk);
        cmd_valid2 = 1'b1;
        cmd_op2 = 4'(op);
        cmd_rsel2 = 3'(rs);
        @(posedge clk);
        #1 cmd_valid2 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (mem_req2 && mem_ack2) acks++;
            if (done2) begin
                done_k = k;
                break;
            end
        end
        if (done_k == 0) chk("w_done_timeout", 0, 1);
    endtask

    initial begin
        int a2;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0000] = 8'h07; mem[16'h0001] = 8'h12; mem[16'h0002] = 8'h34;
        mem[16'h1234] = 8'h20; mem[16'h1235] = 8'h00;
        mem[16'h1236] = 8'h20; mem[16'h1237] = 8'h01;
        mem[16'h1238] = 8'h00; mem[16'h1239] = 8'h01;
        mem[16'h123A] = 8'h00; mem[16'h123B] = 8'hF0;
        mem[16'h2000] = 8'hFF; mem[16'h2001] = 8'h01;
        mem[16'h00F0] = 8'h5A;
        for (int i = 0; i < 32; i++) mem2[i] = '0;
        mem2[1] = 16'h0010; mem2[3] = 16'h0006; mem2[16] = 16'hFFFF;

        m_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_ac", ac_out, 8'h00);
        chk("rst_z", flag_z, 1);
        chk("rst_c", flag_c, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_req", mem_req, 0);
        chk_en = 1'b1;

        run_cmd(1, 0, 3);
        chk("fop_ir", opcode, 8'h07);
        chk("fop_pc", pc_out, 16'h0001);
        chk("fop_req4", last_reqc, 4);

        run_cmd(2, 0, 0);
        run_cmd(8, 0, 0);
        chk("jmp_pc", pc_out, 16'h1234);

        run_cmd(2, 0, 1);
        run_cmd(3, 0, 2);
        chk("ld_ff", ac_out, 8'hFF);
        run_cmd(5, 2, 0);
        run_cmd(2, 0, 0);
        run_cmd(3, 0, 0);
        chk("ld_01", ac_out, 8'h01);
        run_cmd(1, 0, 0);
        run_cmd(7, 2, 0);
        chk("add_ac", ac_out, 8'h00);
        chk("add_z", flag_z, 1);
        chk("add_c", flag_c, 1);
        chk("add_n", flag_n, 0);
        run_cmd(1, 0, 1);
        run_cmd(7, 2, 0);
        chk("sub_ac", ac_out, 8'h01);
        chk("sub_c", flag_c, 1);

        run_cmd(2, 0, 0);
        run_cmd(3, 0, 0);
        run_cmd(4, 0, 2);
        chk("st_we", last_we, 1);
        chk("st_addr", last_addr, 16'h00F0);
        chk("st_wdata", last_wdata, 8'h5A);
        chk("st_req3", last_reqc, 3);
        run_cmd(9, 0, 0);
        chk("jmpz_pc", pc_out, 16'h123C);

        // Abandon a STORE mid-wait with reset, then offer a stray ack.
        chk_en = 1'b0;
        @(negedge clk);
        lat = 100;
        cmd_valid = 1'b1;
        cmd_op = 4'd4;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_req", mem_req, 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mid_req0", mem_req, 0);
        chk("mid_pc", pc_out, 16'h0000);
        chk("mid_z", flag_z, 1);
        chk("mid_ready", cmd_ready, 1);
        stray = 1'b1;
        @(posedge clk);
        #1 stray = 1'b0;
        @(negedge clk);
        chk("stray_done", done, 0);
        chk("stray_ready", cmd_ready, 1);
        chk("stray_req", mem_req, 0);
        m_reset();
        chk_en = 1'b1;

        for (int i = 0; i < 400; i++) begin
            run_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
        end

        run2(2, 0, a2);
        chk("w_fa_acks", a2, 2);
        chk("w_fa_pc", pc_out2, 32'h2);
        run2(3, 0, a2);
        chk("w_ld", ac_out2, 16'hFFFF);
        run2(5, 7, a2);
        run2(1, 0, a2);
        run2(7, 7, a2);
        chk("w_add_ac", ac_out2, 16'hFFFE);
        chk("w_add_c", flag_c2, 1);
        chk("w_add_n", flag_n2, 1);
        run2(3, 0, a2);
        run2(1, 0, a2);
        chk("w_ir", opcode2, 16'h0006);
        run2(7, 0, a2);
        chk("w_inc_ac", ac_out2, 16'h0000);
        chk("w_inc_c", flag_c2, 1);
        chk("w_inc_z", flag_z2, 1);
        chk("w_inc_n", flag_n2, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
